// File: rtl/fp_mul_host.sv
// fp_mul_host: parallel request/response front end for the byte-serial FP_MUL
// double-precision multiplier (16 operand bytes out, 8 result bytes back).
module fp_mul_host #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [63:0] OP_A,
  input  logic [63:0] OP_B,
  output logic        RES_VALID,
  output logic [63:0] RESULT,
  output logic        TIMEOUT_ERR,
  output logic        ENABLE,
  output logic [7:0]  DATA_IN,
  input  logic [7:0]  DATA_OUT,
  input  logic        READY
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SEND = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] RECV = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT);
  localparam logic [WCW-1:0] WAIT_ONE   = WCW'(1);
  localparam logic [63:0]    QNAN       = 64'h7FF8_0000_0000_0000;

  logic [2:0]     state;
  logic [3:0]     cnt;
  logic [3:0]     cnt_inc;
  logic [WCW-1:0] wait_cnt;
  logic [127:0]   operands;
  logic [63:0]    shadow;

  always_comb begin
    REQ_READY = (state == IDLE);
    cnt_inc   = cnt + 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      wait_cnt    <= '0;
      operands    <= '0;
      shadow      <= '0;
      ENABLE      <= 1'b0;
      DATA_IN     <= '0;
      RES_VALID   <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      RESULT      <= '0;
    end else begin
      RES_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ_VALID) begin
            operands <= {OP_B, OP_A};
            cnt      <= '0;
            ENABLE   <= 1'b1;
            DATA_IN  <= OP_A[7:0];
            state    <= SEND;
          end
        end
        SEND: begin
          // DATA_IN is registered, so the byte for the next count is loaded here.
          if (cnt == 4'd15) begin
            ENABLE   <= 1'b0;
            DATA_IN  <= '0;
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            cnt     <= cnt_inc;
            DATA_IN <= operands[{cnt_inc, 3'b000} +: 8];
          end
        end
        WAIT: begin
          if (READY) begin
            shadow[7:0] <= DATA_OUT;
            cnt         <= 4'd1;
            state       <= RECV;
          end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT)) begin
            RESULT      <= QNAN;
            TIMEOUT_ERR <= 1'b1;
            RES_VALID   <= 1'b1;
            state       <= RESP;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        RECV: begin
          shadow[{cnt[2:0], 3'b000} +: 8] <= DATA_OUT;
          if (cnt == 4'd7) begin
            RESULT      <= {DATA_OUT, shadow[55:0]};
            TIMEOUT_ERR <= 1'b0;
            RES_VALID   <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RESP: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_host.sv
// Bench for fp_mul_host: an FP_MUL responder model that multiplies the bytes it
// receives, plus a monitor recording the operand stream and every result pulse.
module tb_fp_mul_host;

  localparam int TMO = 16;

  logic        CLK;
  logic        RESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [63:0] OP_A;
  logic [63:0] OP_B;
  logic        RES_VALID;
  logic [63:0] RESULT;
  logic        TIMEOUT_ERR;
  logic        ENABLE;
  logic [7:0]  DATA_IN;
  logic [7:0]  DATA_OUT;
  logic        READY;

  fp_mul_host #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .OP_A(OP_A), .OP_B(OP_B), .RES_VALID(RES_VALID), .RESULT(RESULT),
    .TIMEOUT_ERR(TIMEOUT_ERR), .ENABLE(ENABLE), .DATA_IN(DATA_IN),
    .DATA_OUT(DATA_OUT), .READY(READY)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // responder controls
  bit          resp_on    = 1'b0;
  bit          ovr_en     = 1'b0;
  logic [63:0] ovr_val    = '0;
  int unsigned resp_delay = 0;
  int          spur_at    = -1;
  logic        resp_ready = 1'b0;
  logic [7:0]  resp_data  = '0;
  logic        spur_send  = 1'b0;
  logic        spur_idle  = 1'b0;

  assign READY    = resp_ready | spur_send | spur_idle;
  assign DATA_OUT = (spur_send | spur_idle) ? 8'hA5 : resp_data;

  // monitor state
  int          cyc = 0;
  int          wait_entry = 0;
  int          en_len = 0;
  int          last_en_len = 0;
  int          rv_long = 0;
  logic [7:0]  tx[$];
  logic [63:0] rv_res[$];
  logic        rv_err[$];
  int          rv_cyc[$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic logic [63:0] rand_fp();
    logic [10:0] e;
    e = 11'(1003 + $urandom_range(0, 40));
    return {1'($urandom_range(0, 1)), e, 20'($urandom), 32'($urandom)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // FP_MUL model: multiplies the received operands unless a fixed answer is set.
  logic       r_prev_en = 1'b0;
  logic [7:0] rx[$];
  logic [63:0] ra, rb, rval;
  initial begin
    forever begin
      @(negedge CLK);
      spur_send = 1'b0;
      if (ENABLE) begin
        if (spur_at >= 0 && rx.size() == spur_at) spur_send = 1'b1;
        rx.push_back(DATA_IN);
        r_prev_en = 1'b1;
      end else if (r_prev_en) begin
        r_prev_en = 1'b0;
        if (resp_on && rx.size() == 16) begin
          for (int i = 0; i < 8; i++) begin
            ra[8*i +: 8] = rx[i];
            rb[8*i +: 8] = rx[i+8];
          end
          rval = ovr_en ? ovr_val : fmul(ra, rb);
          repeat (resp_delay) @(negedge CLK);
          for (int i = 0; i < 8; i++) begin
            resp_ready = (i == 0);
            resp_data  = rval[8*i +: 8];
            @(negedge CLK);
          end
          resp_ready = 1'b0;
          resp_data  = '0;
        end
        rx.delete();
      end
    end
  end

  logic mon_prev_en = 1'b0;
  logic rv_prev = 1'b0;
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (ENABLE) begin
        tx.push_back(DATA_IN);
        en_len++;
      end else if (mon_prev_en) begin
        last_en_len = en_len;
        en_len      = 0;
        wait_entry  = cyc;
      end
      mon_prev_en = ENABLE;
      if (RES_VALID) begin
        rv_res.push_back(RESULT);
        rv_err.push_back(TIMEOUT_ERR);
        rv_cyc.push_back(cyc);
        if (rv_prev) rv_long++;
      end
      rv_prev = RES_VALID;
    end
  end

  task automatic clear_mon();
    tx.delete();
    rv_res.delete();
    rv_err.delete();
    rv_cyc.delete();
    rv_long = 0;
  endtask

  // Returns one cycle into SEND, with the operand inputs scrambled.
  task automatic send_req(input logic [63:0] a, input logic [63:0] b);
    int unsigned n = 0;
    @(negedge CLK);
    REQ_VALID = 1'b1;
    OP_A = a;
    OP_B = b;
    while (!REQ_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("req_ready_seen", 64'(REQ_READY), 64'd1);
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    OP_A = {$urandom, $urandom};
    OP_B = {$urandom, $urandom};
  endtask

  task automatic wait_res(input int n, input int unsigned limit);
    int unsigned k = 0;
    while (rv_res.size() < n && k < limit) begin
      @(posedge CLK);
      k++;
    end
    check("res_seen", 64'(rv_res.size() >= n), 64'd1);
  endtask

  task automatic run_txn(input string name, input logic [63:0] a, input logic [63:0] b,
                         input bit ovr, input logic [63:0] ov, input int unsigned dly);
    logic [63:0] txa, txb, exp;
    txa = 'x;
    txb = 'x;
    clear_mon();
    ovr_en = ovr;
    ovr_val = ov;
    resp_delay = dly;
    resp_on = 1'b1;
    send_req(a, b);
    wait_res(1, 200);
    repeat (3) @(posedge CLK);
    exp = ovr ? ov : fmul(a, b);
    if (tx.size() >= 16) begin
      for (int i = 0; i < 8; i++) begin
        txa[8*i +: 8] = tx[i];
        txb[8*i +: 8] = tx[i+8];
      end
    end
    check({name, "_txlen"}, 64'(tx.size()), 64'd16);
    check({name, "_enlen"}, 64'(last_en_len), 64'd16);
    check({name, "_tx_a"}, txa, a);
    check({name, "_tx_b"}, txb, b);
    check({name, "_nres"}, 64'(rv_res.size()), 64'd1);
    check({name, "_rvlong"}, 64'(rv_long), 64'd0);
    if (rv_res.size() > 0) begin
      check({name, "_result"}, rv_res[0], exp);
      check({name, "_err"}, 64'(rv_err[0]), 64'd0);
      check({name, "_latency"}, 64'(rv_cyc[0] - wait_entry), 64'(dly + 8));
    end
  endtask

  task automatic reset_pulse_check(input string name);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check({name, "_enable"}, 64'(ENABLE), 64'd0);
    check({name, "_data_in"}, 64'(DATA_IN), 64'd0);
    check({name, "_req_ready"}, 64'(REQ_READY), 64'd1);
    repeat (30) @(posedge CLK);
    check({name, "_no_res"}, 64'(rv_res.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] pa[3];
    logic [63:0] pb[3];
    int unsigned dly;

    RESET = 1'b1;
    REQ_VALID = 1'b0;
    OP_A = '0;
    OP_B = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_enable", 64'(ENABLE), 64'd0);
    check("rst_data_in", 64'(DATA_IN), 64'd0);
    check("rst_res_valid", 64'(RES_VALID), 64'd0);
    check("rst_timeout_err", 64'(TIMEOUT_ERR), 64'd0);
    check("rst_result", RESULT, 64'd0);
    check("rst_req_ready", 64'(REQ_READY), 64'd1);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    run_txn("basic", 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, '0, 5);
    run_txn("order", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1,
            64'h1122_3344_5566_7788, 3);

    // timeout: responder stays silent
    clear_mon();
    resp_on = 1'b0;
    send_req(rand_fp(), rand_fp());
    wait_res(1, 200);
    @(negedge CLK);
    check("tmo_req_ready", 64'(REQ_READY), 64'd1);
    if (rv_res.size() > 0) begin
      check("tmo_result", rv_res[0], 64'h7FF8_0000_0000_0000);
      check("tmo_err", 64'(rv_err[0]), 64'd1);
      check("tmo_latency", 64'(rv_cyc[0] - wait_entry), 64'(TMO + 1));
    end

    // spurious READY in IDLE and during SEND byte 10
    clear_mon();
    @(negedge CLK);
    spur_idle = 1'b1;
    @(negedge CLK);
    spur_idle = 1'b0;
    spur_at = 10;
    run_txn("spur", rand_fp(), rand_fp(), 1'b0, '0, 4);
    spur_at = -1;
    @(negedge CLK);
    spur_idle = 1'b1;
    @(negedge CLK);
    spur_idle = 1'b0;
    repeat (10) @(posedge CLK);
    check("spur_idle_no_res", 64'(rv_res.size()), 64'd1);
    check("spur_idle_req_ready", 64'(REQ_READY), 64'd1);

    // reset during SEND byte 5
    clear_mon();
    resp_on = 1'b0;
    send_req(rand_fp(), rand_fp());
    repeat (5) @(posedge CLK);
    #1;
    reset_pulse_check("rst_send");

    // reset during RECV byte 3
    clear_mon();
    resp_on = 1'b1;
    ovr_en = 1'b0;
    dly = 2;
    resp_delay = dly;
    send_req(rand_fp(), rand_fp());
    repeat (19 + dly) @(posedge CLK);
    #1;
    reset_pulse_check("rst_recv");
    run_txn("post_rst", 64'h3FF8_0000_0000_0000, 64'h4010_0000_0000_0000, 1'b0, '0, 2);

    for (int t = 0; t < 6; t++) begin
      run_txn($sformatf("rand%0d", t), rand_fp(), rand_fp(), 1'b0, '0, $urandom_range(0, 12));
    end

    // back-to-back with REQ_VALID held across three requests
    clear_mon();
    resp_on = 1'b1;
    ovr_en = 1'b0;
    dly = 1;
    resp_delay = dly;
    for (int k = 0; k < 3; k++) begin
      pa[k] = rand_fp();
      pb[k] = rand_fp();
    end
    @(negedge CLK);
    REQ_VALID = 1'b1;
    OP_A = pa[0];
    OP_B = pb[0];
    for (int k = 0; k < 3; k++) begin
      int unsigned n = 0;
      while (!REQ_READY && n < 200) begin
        @(negedge CLK);
        n++;
      end
      @(posedge CLK);
      #1;
      if (k < 2) begin
        OP_A = pa[k+1];
        OP_B = pb[k+1];
      end else begin
        REQ_VALID = 1'b0;
      end
    end
    wait_res(3, 300);
    repeat (3) @(posedge CLK);
    check("b2b_nres", 64'(rv_res.size()), 64'd3);
    if (rv_res.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("b2b_result%0d", k), rv_res[k], fmul(pa[k], pb[k]));
        check($sformatf("b2b_err%0d", k), 64'(rv_err[k]), 64'd0);
      end
      // 16 SEND, dly+1 WAIT, 7 RECV, 1 RESP, 1 IDLE acceptance cycle
      for (int k = 1; k < 3; k++) begin
        check($sformatf("b2b_gap%0d", k), 64'(rv_cyc[k] - rv_cyc[k-1]),
              64'(16 + (dly + 1) + 7 + 1 + 1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
